seg_scan_driver: RTL

- Time-multiplexed scanner for a multi-digit 7-segment display; sits directly upstream of the 5-bit-code to 7-segment decoder.
- Holds one 5-bit code per digit in a double-buffered register file.
- Cycles through digits, driving the current digit's code on `data` (to the decoder) and a one-hot digit enable.
- Provides ghost-suppression blanking, optional leading-zero blanking and tear-free frame updates.

---
 rtl/seg_scan_driver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 7-segment digit scanner with double-buffered codes
//
// Purpose: scans DIGITS digit slots of REFRESH_DIV clocks each. Every slot starts with
// GHOST_CYCLES blank clocks, then drives the digit's 5-bit code and its one-hot enable.
// Codes are written into a shadow file and copied to the displayed file only at a frame
// boundary after a load request, so a frame never shows a mix of old and new values.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   wr_en        write shadow[wr_addr] <= wr_data
//   wr_addr      shadow digit index (out-of-range writes dropped)
//   wr_data      digit code, 0..15 hex, 31 = blank
//   load         request shadow -> active copy at next frame boundary
//   lzb_en       leading-zero blanking enable (live)
//   data         code to the 7-segment decoder
//   digit_en     one-hot digit enable, active high
//   frame_done   one-cycle pulse on the first cycle of each new frame
//   load_pending load requested but not yet applied
module seg_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GHOST_CYCLES = 16,
   localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
   localparam int CW = $clog2(REFRESH_DIV)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [4:0]        wr_data,
   input  logic              load,
   input  logic              lzb_en,
   output logic [4:0]        data,
   output logic [DIGITS-1:0] digit_en,
   output logic              frame_done,
   output logic              load_pending
);

   localparam logic [4:0] BLANK = 5'd31;

   logic [CW-1:0]     r_cnt;
   logic [AW-1:0]     r_idx;
   logic [4:0]        r_shadow [DIGITS];
   logic [4:0]        r_active [DIGITS];
   logic              r_pending;
   logic [4:0]        r_data;
   logic [DIGITS-1:0] r_digit_en;
   logic              r_frame_done;

   logic              w_slot_end;
   logic              w_frame_end;
   logic              w_load_req;
   logic              w_apply;
   logic [CW-1:0]     w_cnt_nxt;
   logic [AW-1:0]     w_idx_nxt;
   logic              w_pending_nxt;
   logic [4:0]        w_active_nxt [DIGITS];
   logic [DIGITS-1:0] w_blank;
   logic              w_all_zero;
   logic [4:0]        w_data_nxt;
   logic [DIGITS-1:0] w_en_nxt;

   assign w_slot_end  = (r_cnt == CW'(REFRESH_DIV - 1));
   assign w_frame_end = w_slot_end && (r_idx == AW'(DIGITS - 1));
   // A load arriving on the boundary edge itself still counts for that boundary.
   assign w_load_req  = r_pending | load;
   assign w_apply     = w_frame_end & w_load_req;

   // Next-state counters and buffers
   always_comb begin
      w_cnt_nxt     = w_slot_end ? '0 : r_cnt + CW'(1);
      w_idx_nxt     = r_idx;
      if (w_slot_end) begin
         w_idx_nxt = w_frame_end ? '0 : r_idx + AW'(1);
      end
      w_pending_nxt = w_frame_end ? 1'b0 : w_load_req;
      for (int i = 0; i < DIGITS; i++) begin
         // Copy uses pre-edge shadow, so a same-edge write is not displayed yet.
         w_active_nxt[i] = w_apply ? r_shadow[i] : r_active[i];
      end
   end

   // Leading-zero blanking: digit i blanks only if it and every higher digit are zero.
   always_comb begin
      w_blank    = '0;
      w_all_zero = lzb_en;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_all_zero = w_all_zero && (w_active_nxt[i] == 5'd0);
         w_blank[i] = w_all_zero;
      end
   end

   // Outputs are computed from next-state values so they line up with cnt/idx.
   always_comb begin
      w_data_nxt = BLANK;
      w_en_nxt   = '0;
      if (int'(w_cnt_nxt) >= GHOST_CYCLES) begin
         w_en_nxt   = DIGITS'(1) << w_idx_nxt;
         w_data_nxt = w_blank[w_idx_nxt] ? BLANK : w_active_nxt[w_idx_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pending    <= 1'b0;
         r_data       <= BLANK;
         r_digit_en   <= '0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            r_shadow[i] <= 5'd0;
            r_active[i] <= 5'd0;
         end
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_pending    <= w_pending_nxt;
         r_data       <= w_data_nxt;
         r_digit_en   <= w_en_nxt;
         r_frame_done <= w_frame_end;
         for (int i = 0; i < DIGITS; i++) begin
            r_active[i] <= w_active_nxt[i];
         end
         if (wr_en && (int'(wr_addr) < DIGITS)) begin
            r_shadow[wr_addr] <= wr_data;
         end
      end
   end

   assign data         = r_data;
   assign digit_en     = r_digit_en;
   assign frame_done   = r_frame_done;
   assign load_pending = r_pending;

endmodule
